// File: rtl/cam_pkg.sv
// Shared definitions for the camera sync timing monitor: FSM state encoding
// and the default counter widths.
package cam_pkg;

    localparam int CAM_PIX_W  = 12;
    localparam int CAM_LINE_W = 11;
    localparam int CAM_FRM_W  = 16;

    typedef enum logic [1:0] {
        CAM_ST_IDLE   = 2'd0,
        CAM_ST_ALIGN  = 2'd1,
        CAM_ST_VBLANK = 2'd2,
        CAM_ST_ACTIVE = 2'd3
    } cam_state_t;

endpackage

// File: rtl/cam_deglitch.sv
// Per-channel level deglitch filter: a channel's output follows its input only
// after the input has held a new level for FILT_LEN consecutive cycles.
module cam_deglitch #(
    parameter int WIDTH    = 2,
    parameter int FILT_LEN = 3
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] raw,
    output logic [WIDTH-1:0] clean
);

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_chan
            logic [3:0] run_reg;
            logic       level_reg;

            // run_reg counts consecutive samples that disagree with the output.
            always_ff @(posedge clk) begin
                if (!reset_n) begin
                    run_reg   <= '0;
                    level_reg <= 1'b0;
                end else if (raw[gi] == level_reg) begin
                    run_reg <= '0;
                end else if (run_reg == 4'(FILT_LEN - 1)) begin
                    level_reg <= raw[gi];
                    run_reg   <= '0;
                end else begin
                    run_reg <= run_reg + 4'd1;
                end
            end

            assign clean[gi] = level_reg;
        end
    endgenerate

endmodule

// File: rtl/cam_timing_mon.sv
// Camera sync timing monitor: line length, lines per frame, frame count and
// malformed-timing flags. Define CAM_TIMING_MON_FILTER_EN to deglitch vsync/href.
module cam_timing_mon
    import cam_pkg::*;
#(
    parameter int PIX_W    = CAM_PIX_W,
    parameter int LINE_W   = CAM_LINE_W,
    parameter int FRM_W    = CAM_FRM_W,
    parameter int FILT_LEN = 3
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              enable,
    input  logic              vsync,
    input  logic              href,
    output logic              line_done,
    output logic              frame_done,
    output logic [PIX_W-1:0]  pix_cnt_last,
    output logic [LINE_W-1:0] line_cnt_last,
    output logic [FRM_W-1:0]  frame_cnt,
    output logic              err_len,
    output logic              err_ovf
);

    logic vsync_s;
    logic href_s;

`ifdef CAM_TIMING_MON_FILTER_EN
    logic [1:0] filt_out;

    cam_deglitch #(
        .WIDTH    (2),
        .FILT_LEN (FILT_LEN)
    ) u_deglitch (
        .clk     (clk),
        .reset_n (reset_n),
        .raw     ({vsync, href}),
        .clean   (filt_out)
    );

    assign vsync_s = filt_out[1];
    assign href_s  = filt_out[0];
`else
    logic unused_filt_len;
    assign unused_filt_len = ^FILT_LEN;
    assign vsync_s = vsync;
    assign href_s  = href;
`endif

    cam_state_t        state_reg, state_next;
    logic              vsync_q, href_q;
    logic              armed_reg;
    logic              ref_valid_reg;
    logic [PIX_W-1:0]  pix_cnt_reg, ref_len_reg, pix_last_reg;
    logic [LINE_W-1:0] line_cnt_reg, line_last_reg;
    logic [FRM_W-1:0]  frame_cnt_reg;
    logic              line_done_reg, frame_done_reg;
    logic              err_len_reg, err_ovf_reg;

    logic              vs_rise, vs_fall, hr_rise, hr_fall;
    logic              in_active, enable_start, frame_start;
    logic              line_close, frame_close, arm_line;
    logic              pix_max, line_max;
    logic [LINE_W-1:0] line_cnt_inc;

    assign vs_rise = vsync_s & ~vsync_q;
    assign vs_fall = ~vsync_s & vsync_q;
    assign hr_rise = href_s & ~href_q;
    assign hr_fall = ~href_s & href_q;

    assign pix_max      = (pix_cnt_reg == '1);
    assign line_max     = (line_cnt_reg == '1);
    assign line_cnt_inc = line_max ? line_cnt_reg : line_cnt_reg + LINE_W'(1);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_reg <= CAM_ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        in_active    = 1'b0;
        enable_start = 1'b0;
        frame_start  = 1'b0;
        line_close   = 1'b0;
        frame_close  = 1'b0;
        arm_line     = 1'b0;
        if (!enable) begin
            state_next = CAM_ST_IDLE;
        end else begin
            case (state_reg)
                CAM_ST_IDLE: begin
                    enable_start = 1'b1;
                    state_next   = CAM_ST_ALIGN;
                end
                CAM_ST_ALIGN: begin
                    if (vs_rise) state_next = CAM_ST_VBLANK;
                end
                CAM_ST_VBLANK: begin
                    if (vs_fall) begin
                        frame_start = 1'b1;
                        state_next  = CAM_ST_ACTIVE;
                    end
                end
                CAM_ST_ACTIVE: begin
                    in_active   = 1'b1;
                    line_close  = hr_fall & armed_reg;
                    frame_close = vs_rise;
                    // A line starting on the frame-closing edge belongs to no frame.
                    arm_line    = hr_rise & ~vs_rise;
                    if (vs_rise) state_next = CAM_ST_VBLANK;
                end
                default: state_next = CAM_ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            vsync_q        <= 1'b0;
            href_q         <= 1'b0;
            armed_reg      <= 1'b0;
            ref_valid_reg  <= 1'b0;
            pix_cnt_reg    <= '0;
            ref_len_reg    <= '0;
            pix_last_reg   <= '0;
            line_cnt_reg   <= '0;
            line_last_reg  <= '0;
            frame_cnt_reg  <= '0;
            line_done_reg  <= 1'b0;
            frame_done_reg <= 1'b0;
            err_len_reg    <= 1'b0;
            err_ovf_reg    <= 1'b0;
        end else begin
            vsync_q        <= vsync_s;
            href_q         <= href_s;
            line_done_reg  <= line_close;
            frame_done_reg <= frame_close;
            if (!enable) begin
                armed_reg   <= 1'b0;
                err_len_reg <= 1'b0;
                err_ovf_reg <= 1'b0;
            end else begin
                if (enable_start) frame_cnt_reg <= '0;
                if (frame_start) begin
                    line_cnt_reg  <= '0;
                    ref_valid_reg <= 1'b0;
                end
                if (!in_active) begin
                    armed_reg <= 1'b0;
                end else begin
                    if (arm_line) begin
                        armed_reg   <= 1'b1;
                        pix_cnt_reg <= PIX_W'(1);
                    end else if (armed_reg && href_s) begin
                        if (pix_max) err_ovf_reg <= 1'b1;
                        else         pix_cnt_reg <= pix_cnt_reg + PIX_W'(1);
                    end
                    if (line_close) begin
                        armed_reg    <= 1'b0;
                        pix_last_reg <= pix_cnt_reg;
                        line_cnt_reg <= line_cnt_inc;
                        if (line_max) err_ovf_reg <= 1'b1;
                        if (!ref_valid_reg) begin
                            ref_len_reg   <= pix_cnt_reg;
                            ref_valid_reg <= 1'b1;
                        end else if (pix_cnt_reg != ref_len_reg) begin
                            err_len_reg <= 1'b1;
                        end
                    end
                    // A line closing on the same edge is counted in this frame.
                    if (frame_close) begin
                        armed_reg     <= 1'b0;
                        line_last_reg <= line_close ? line_cnt_inc : line_cnt_reg;
                        frame_cnt_reg <= frame_cnt_reg + FRM_W'(1);
                    end
                end
            end
        end
    end

    assign line_done     = line_done_reg;
    assign frame_done    = frame_done_reg;
    assign pix_cnt_last  = pix_last_reg;
    assign line_cnt_last = line_last_reg;
    assign frame_cnt     = frame_cnt_reg;
    assign err_len       = err_len_reg;
    assign err_ovf       = err_ovf_reg;

endmodule

// File: tb/tb_cam_timing_mon.sv
// Self-checking bench for cam_timing_mon: directed frames plus randomized frames
// checked against a frame/line level reference model.
`timescale 1ns/1ps
module tb_cam_timing_mon;

    localparam int PIX_W    = 12;
    localparam int LINE_W   = 11;
    localparam int FRM_W    = 16;
    localparam int FILT_LEN = 3;
`ifdef CAM_TIMING_MON_FILTER_EN
    localparam int XLAT = FILT_LEN;
`else
    localparam int XLAT = 0;
`endif
    localparam int PIX_MAX  = (1 << PIX_W) - 1;
    localparam int LINE_MAX = (1 << LINE_W) - 1;
    localparam int GAP_MIN  = (XLAT + 1 > 3) ? XLAT + 1 : 3;

    logic              clk = 1'b0;
    logic              reset_n, enable, vsync, href;
    logic              line_done, frame_done;
    logic [PIX_W-1:0]  pix_cnt_last;
    logic [LINE_W-1:0] line_cnt_last;
    logic [FRM_W-1:0]  frame_cnt;
    logic              err_len, err_ovf;

    always #5 clk = ~clk;

    cam_timing_mon #(
        .PIX_W    (PIX_W),
        .LINE_W   (LINE_W),
        .FRM_W    (FRM_W),
        .FILT_LEN (FILT_LEN)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .enable        (enable),
        .vsync         (vsync),
        .href          (href),
        .line_done     (line_done),
        .frame_done    (frame_done),
        .pix_cnt_last  (pix_cnt_last),
        .line_cnt_last (line_cnt_last),
        .frame_cnt     (frame_cnt),
        .err_len       (err_len),
        .err_ovf       (err_ovf)
    );

    int checks = 0;
    int errors = 0;
    int ld_seen = 0, fd_seen = 0, ld_exp = 0, fd_exp = 0;

    // Reference model: what the debug registers should read, per the frame rules.
    bit sync_seen = 0;  // a vsync rise was seen since the monitor was enabled
    bit in_frame  = 0;  // current frame opened by a vsync fall after alignment
    int cur_lines = 0;
    int ref_len   = -1;
    int m_pix = 0, m_lines = 0, m_frames = 0;
    bit m_errl = 0, m_ovf = 0;

    task automatic tick();
        @(posedge clk);
        #1;
        ld_seen += int'(line_done);
        fd_seen += int'(frame_done);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_regs(input string tag);
        check({tag, ".pix_cnt_last"},  32'(pix_cnt_last),  32'(m_pix));
        check({tag, ".line_cnt_last"}, 32'(line_cnt_last), 32'(m_lines));
        check({tag, ".frame_cnt"},     32'(frame_cnt),     32'(m_frames));
        check({tag, ".err_len"},       32'(err_len),       32'(m_errl));
        check({tag, ".err_ovf"},       32'(err_ovf),       32'(m_ovf));
    endtask

    task automatic wait_lat(input string tag);
        for (int i = 0; i < XLAT; i++) begin
            check(tag, 32'(line_done | frame_done), 32'd0);
            tick();
        end
    endtask

    function automatic void model_line(input int len);
        int p;
        p = (len > PIX_MAX) ? PIX_MAX : len;
        if (len > PIX_MAX) m_ovf = 1;
        if (ref_len < 0) ref_len = p;
        else if (p != ref_len) m_errl = 1;
        if (cur_lines == LINE_MAX) m_ovf = 1;
        else cur_lines++;
        m_pix = p;
        ld_exp++;
    endfunction

    task automatic drive_line(input int len, input int gap);
        bit meas;
        meas = in_frame;
        href = 1'b1;
        repeat (len) tick();
        href = 1'b0;
        tick();
        wait_lat("line.early");
        if (meas) model_line(len);
        check("line.line_done", 32'(line_done), 32'(meas));
        check_regs("line");
        $display("line  len=%0d measured=%0d pix_cnt_last=%0d err_len=%0d err_ovf=%0d",
                 len, meas, pix_cnt_last, err_len, err_ovf);
        repeat ((gap - 1 - XLAT > 0) ? gap - 1 - XLAT : 0) tick();
    endtask

    // last_len > 0: a final line whose href fall coincides with the vsync rise.
    task automatic close_frame(input int last_len);
        bit meas;
        meas = in_frame;
        if (last_len > 0) begin
            href = 1'b1;
            repeat (last_len) tick();
        end
        href  = 1'b0;
        vsync = 1'b1;
        tick();
        wait_lat("frame.early");
        if (meas && last_len > 0) model_line(last_len);
        if (meas) begin
            m_lines  = cur_lines;
            m_frames = (m_frames + 1) % (1 << FRM_W);
            fd_exp++;
        end
        if (enable) sync_seen = 1;
        in_frame = 0;
        check("frame.line_done", 32'(line_done), 32'(meas && last_len > 0));
        check("frame.frame_done", 32'(frame_done), 32'(meas));
        check_regs("frame");
        $display("frame measured=%0d line_cnt_last=%0d frame_cnt=%0d err_len=%0d err_ovf=%0d",
                 meas, line_cnt_last, frame_cnt, err_len, err_ovf);
        repeat (3) tick();
    endtask

    // stale: href already high when vsync falls; that line must be ignored.
    task automatic open_frame(input bit stale);
        if (stale) begin
            href = 1'b1;
            repeat (4) tick();
        end
        vsync = 1'b0;
        tick();
        if (sync_seen) begin
            in_frame  = 1;
            cur_lines = 0;
            ref_len   = -1;
        end
        if (stale) begin
            repeat (5) tick();
            href = 1'b0;
            tick();
            repeat (XLAT + 2) tick();
            check("stale.line_done_count", 32'(ld_seen), 32'(ld_exp));
        end
        repeat (GAP_MIN + 3) tick();
    endtask

    task automatic set_enable(input bit en);
        repeat (XLAT + 2) tick();
        enable = en;
        tick();
        if (!en) begin
            m_errl    = 0;
            m_ovf     = 0;
            sync_seen = 0;
            in_frame  = 0;
        end else begin
            m_frames = 0;
        end
        check_regs(en ? "enable_rise" : "enable_fall");
        $display("enable=%0d frame_cnt=%0d err_len=%0d err_ovf=%0d", en, frame_cnt, err_len, err_ovf);
        repeat (2) tick();
    endtask

    initial begin
        int nl, base, len, gap;

        // Reset with random inputs.
        reset_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            enable = 1'($urandom_range(0, 1));
            vsync  = 1'($urandom_range(0, 1));
            href   = 1'($urandom_range(0, 1));
            tick();
            check("reset.pulses", 32'(line_done | frame_done), 32'd0);
        end
        check_regs("reset");
        enable = 1'b0;
        vsync  = 1'b0;
        href   = 1'b0;
        reset_n = 1'b1;
        repeat (XLAT + 2) tick();
        check("reset.pulse_count", 32'(ld_seen + fd_seen), 32'd0);

        // Nominal frame: alignment vsync, then 4 lines of 640.
        set_enable(1);
        close_frame(0);
        open_frame(0);
        for (int i = 0; i < 4; i++) drive_line(640, 8);
        close_frame(0);

        // Stale href at frame start; line 3 closes with the vsync rise.
        open_frame(1);
        drive_line(640, 8);
        drive_line(640, 8);
        close_frame(640);

        // Length mismatch, then counter saturation.
        open_frame(0);
        drive_line(640, 8);
        drive_line(640, 8);
        drive_line(639, 8);
        close_frame(0);
        open_frame(0);
        drive_line(5000, 8);
        close_frame(0);

        // Drop enable; re-enable mid-frame with 2 lines left.
        set_enable(0);
        open_frame(0);
        drive_line(640, 8);
        set_enable(1);
        drive_line(640, 8);
        drive_line(640, 8);
        close_frame(0);
        open_frame(0);
        drive_line(640, 8);
        drive_line(640, 8);
        close_frame(0);

`ifdef CAM_TIMING_MON_FILTER_EN
        // Short href glitch is dropped; a FILT_LEN-wide pulse is measured.
        open_frame(0);
        href = 1'b1;
        repeat (FILT_LEN - 1) tick();
        href = 1'b0;
        repeat (FILT_LEN + 4) tick();
        check("filter.glitch_line_count", 32'(ld_seen), 32'(ld_exp));
        drive_line(FILT_LEN, GAP_MIN + 2);
        close_frame(0);
`endif

        // Randomized frames.
        for (int f = 0; f < 12; f++) begin
            if ($urandom_range(0, 3) == 0) begin
                set_enable(0);
                set_enable(1);
            end
            open_frame(1'($urandom_range(0, 3) == 0));
            nl   = $urandom_range(1, 5);
            base = $urandom_range(3, 30);
            for (int l = 0; l < nl; l++) begin
                len = ($urandom_range(0, 4) == 0) ? base + 1 : base;
                gap = $urandom_range(GAP_MIN, GAP_MIN + 6);
                drive_line(len, gap);
            end
            close_frame(($urandom_range(0, 2) == 0) ? base : 0);
        end

        repeat (XLAT + 4) tick();
        check("total.line_done_pulses", 32'(ld_seen), 32'(ld_exp));
        check("total.frame_done_pulses", 32'(fd_seen), 32'(fd_exp));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
